mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM/WB pipeline register and writeback stage of the 16-bit pipelined core. It captures the results of the memory stage and selects the writeback value (ALU result, load data or PC+2). It drives the register file write port (WriteReg/DstReg/DstData) and supplies write-before-read bypassed operands to decode, so a same-cycle write is visible to a same-cycle read. It also owns the sticky halt flag and the retired-instruction counter.

## Interface
- `WIDTH`, 16, datapath width
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hold WB register contents
- `flush`  in  1  load a bubble into WB; priority over `stall`
- `mem_valid`  in  1  MEM stage holds a real instruction
- `mem_reg_write`  in  1  instruction writes a register
- `mem_rd`  in  4  destination register
- `mem_wb_sel`  in  2  0 = ALU result, 1 = load data, 2 = PC+2, 3 = reserved (treated as 0)
- `mem_alu_result`  in  WIDTH  ALU result
- `mem_rdata`  in  WIDTH  data-memory read data
- `mem_pc_plus2`  in  WIDTH  link value
- `mem_halt`  in  1  instruction is HLT
- `SrcReg1`, `SrcReg2`  in  4  decode read addresses (same nets as the register file)
- `SrcData1`, `SrcData2`  in  WIDTH  raw register-file read data
- `WriteReg`  out  1  register-file write enable
- `DstReg`  out  4  register-file write address
- `DstData`  out  WIDTH  register-file write data
- `byp_data1`, `byp_data2`  out  WIDTH  bypassed operands to decode
- `halted`  out  1  sticky; set once HLT retires
- `instret`  out  16  retired-instruction count

## Operation
- WB register fields: valid, reg_write, rd, wb_sel, alu, rdata, pc2, halt, fresh.
- Capture priority on each posedge: `rst` first, then `flush`, then `stall`, then a normal load.
  - `rst`: clear every field.
  - `flush`: valid=0, fresh=1.
  - `stall`: hold all fields; fresh=0.
  - Normal load: capture the `mem_*` inputs; fresh=1.
- Writeback select (combinational from WB fields): `DstData` = alu, rdata or pc2 per wb_sel; sel 3 selects alu.
- `DstReg` = rd, always driven.
- `WriteReg` = valid & reg_write & fresh & (rd != 0) & ~halted.
  - R0 is never written.
  - A stalled instruction writes exactly once, in its first WB cycle.
- Bypass: `byp_dataN` = `DstData` when `WriteReg` & (`DstReg` == `SrcRegN`); otherwise `SrcDataN`. Ports 1 and 2 are independent.
- Retire event = valid & fresh & ~halted.
  - Each retire event increments `instret` by 1, mod 2^16; 0xFFFF wraps to 0x0000.
  - Bubbles and stall-repeat cycles do not count.
- Halt:
  - On a retire event with halt=1, `halted` sets at the next posedge.
  - The HLT itself counts in `instret` and performs no register write.
  - While `halted`=1: `WriteReg`=0, `instret` frozen, bypass reduces to passthrough.
  - Only `rst` clears `halted`.

## Timing
- Reset values:
  - `WriteReg`=0, `DstReg`=0, `DstData`=0, `halted`=0, `instret`=0.
  - `byp_dataN` = `SrcDataN` (passthrough).
- Latency:
  - `mem_*` sampled at edge N.
  - `WriteReg`/`DstReg`/`DstData` valid in cycle N→N+1.
  - Register file commits at edge N+1.
- Bypass is purely combinational in the cycle before the commit edge. Decode sees the new value in the same cycle the write is presented.
- `halted` rises one cycle after the HLT's WB cycle.
- `instret` updates at the edge that ends the retire cycle.
- Simultaneous `flush` and `stall`: flush wins and the bubble is loaded.
- `rst` asserted mid-stall or mid-halt: all state clears at that edge, with no write in the following cycle.
- `mem_valid`=0 on a normal load: bubble; fresh=1 but no write and no count.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random `mem_*` -> `WriteReg`=0, `instret`=0, `halted`=0, `byp_data1`==`SrcData1`.
- **Writeback select:** load rd=5, reg_write=1, alu=0x1234, rdata=0xBEEF, pc2=0x0042 with wb_sel=0, 1, 2, 3 on successive cycles -> `DstData` = 0x1234, 0xBEEF, 0x0042, 0x1234, each one cycle after capture; `instret`=4.
- **Bypass:**
  - WB writes R3=0xA5A5; `SrcReg1`=3, `SrcData1`=0x0000, `SrcReg2`=4, `SrcData2`=0x1111 -> `byp_data1`=0xA5A5, `byp_data2`=0x1111.
  - rd=0 write of 0xFFFF -> `WriteReg`=0 and no bypass for `SrcReg1`=0.
- **Stall/flush:**
  - Capture R7 write, then stall 3 cycles -> `WriteReg` high for 1 cycle only and `instret` +1.
  - `stall`=`flush`=1 -> bubble, `WriteReg`=0.
- **Halt:**
  - Retire 2 instructions, then HLT, then an R2 write -> `instret`=3, `halted`=1 one cycle after HLT's WB, and the R2 write is suppressed.
  - `rst` clears `halted`.
- **Wrap:** retire 65,536 valid instructions from reset -> `instret` returns to 0x0000.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Holds the memory-stage results for one cycle, picks the writeback value,
// drives the register-file write port and forwards a same-cycle write to the
// decode operands. Also owns the sticky halt flag and the retired count.
module mem_wb_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [3:0]       mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [WIDTH-1:0] mem_pc_plus2,
    input  logic             mem_halt,
    input  logic [3:0]       SrcReg1,
    input  logic [3:0]       SrcReg2,
    input  logic [WIDTH-1:0] SrcData1,
    input  logic [WIDTH-1:0] SrcData2,
    output logic             WriteReg,
    output logic [3:0]       DstReg,
    output logic [WIDTH-1:0] DstData,
    output logic [WIDTH-1:0] byp_data1,
    output logic [WIDTH-1:0] byp_data2,
    output logic             halted,
    output logic [15:0]      instret
);

    logic             wb_valid;
    logic             wb_reg_write;
    logic [3:0]       wb_rd;
    logic [1:0]       wb_sel;
    logic [WIDTH-1:0] wb_alu;
    logic [WIDTH-1:0] wb_rdata;
    logic [WIDTH-1:0] wb_pc2;
    logic             wb_halt;
    logic             wb_fresh;
    logic             halted_q;
    logic [15:0]      instret_q;
    logic             retire;

    // WB pipeline register: reset, then flush (bubble), then stall (hold), then load.
    // fresh marks the first cycle an entry sits in WB so a held entry acts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 4'd0;
            wb_sel       <= 2'd0;
            wb_alu       <= '0;
            wb_rdata     <= '0;
            wb_pc2       <= '0;
            wb_halt      <= 1'b0;
            wb_fresh     <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_fresh <= 1'b1;
        end else if (stall) begin
            wb_fresh <= 1'b0;
        end else begin
            wb_valid     <= mem_valid;
            wb_reg_write <= mem_reg_write;
            wb_rd        <= mem_rd;
            wb_sel       <= mem_wb_sel;
            wb_alu       <= mem_alu_result;
            wb_rdata     <= mem_rdata;
            wb_pc2       <= mem_pc_plus2;
            wb_halt      <= mem_halt;
            wb_fresh     <= 1'b1;
        end
    end

    assign retire = wb_valid & wb_fresh & ~halted_q;

    // Retire bookkeeping: count each retiring instruction, latch halt when HLT retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q  <= 1'b0;
            instret_q <= 16'd0;
        end else if (retire) begin
            instret_q <= instret_q + 16'd1;
            if (wb_halt) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Writeback value select; the reserved encoding falls back to the ALU result.
    always_comb begin
        DstData = wb_alu;
        case (wb_sel)
            2'd1:    DstData = wb_rdata;
            2'd2:    DstData = wb_pc2;
            default: DstData = wb_alu;
        endcase
    end

    // HLT never writes a register even if it carries reg_write.
    assign WriteReg = wb_valid & wb_reg_write & wb_fresh & (wb_rd != 4'd0)
                    & ~halted_q & ~wb_halt;
    assign DstReg   = wb_rd;

    assign byp_data1 = (WriteReg && (DstReg == SrcReg1)) ? DstData : SrcData1;
    assign byp_data2 = (WriteReg && (DstReg == SrcReg2)) ? DstData : SrcData2;

    assign halted  = halted_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_valid, mem_reg_write, mem_halt;
    logic [3:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [15:0] mem_alu_result, mem_rdata, mem_pc_plus2;
    logic [3:0]  SrcReg1, SrcReg2;
    logic [15:0] SrcData1, SrcData2;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData, byp_data1, byp_data2;
    logic        halted;
    logic [15:0] instret;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
        .mem_rdata(mem_rdata), .mem_pc_plus2(mem_pc_plus2), .mem_halt(mem_halt),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .SrcData1(SrcData1), .SrcData2(SrcData2),
        .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
        .halted(halted), .instret(instret)
    );

    // Reference model: the instruction occupying writeback, whether this is its
    // first cycle there, the halt flag and the number of retired instructions.
    typedef struct {
        logic        valid;
        logic        rw;
        logic [3:0]  rd;
        logic [1:0]  sel;
        logic [15:0] alu;
        logic [15:0] rdata;
        logic [15:0] pc2;
        logic        halt;
    } instr_t;

    instr_t      m_wb;
    logic        m_first;
    logic        m_halted;
    logic [15:0] m_cnt;

    function automatic logic [15:0] m_value();
        if (m_wb.sel == 2'd1) return m_wb.rdata;
        if (m_wb.sel == 2'd2) return m_wb.pc2;
        return m_wb.alu;
    endfunction

    function automatic logic m_write();
        return m_wb.valid && m_wb.rw && m_first && (m_wb.rd != 4'd0)
               && !m_halted && !m_wb.halt;
    endfunction

    function automatic logic [15:0] m_byp(input logic [3:0] src, input logic [15:0] raw);
        if (m_write() && m_wb.rd == src) return m_value();
        return raw;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_wb     = '{default: '0};
            m_first  = 1'b0;
            m_halted = 1'b0;
            m_cnt    = 16'd0;
        end else begin
            if (m_wb.valid && m_first && !m_halted) begin
                m_cnt = m_cnt + 16'd1;
                if (m_wb.halt) m_halted = 1'b1;
            end
            if (flush) begin
                m_wb.valid = 1'b0;
                m_first    = 1'b1;
            end else if (stall) begin
                m_first = 1'b0;
            end else begin
                m_wb = '{valid: mem_valid, rw: mem_reg_write, rd: mem_rd,
                         sel: mem_wb_sel, alu: mem_alu_result, rdata: mem_rdata,
                         pc2: mem_pc_plus2, halt: mem_halt};
                m_first = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [3:0] rd,
                         input logic [1:0] sel, input logic [15:0] alu,
                         input logic [15:0] rdata, input logic [15:0] pc2,
                         input logic halt);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_rd         = rd;
        mem_wb_sel     = sel;
        mem_alu_result = alu;
        mem_rdata      = rdata;
        mem_pc_plus2   = pc2;
        mem_halt       = halt;
    endtask

    task automatic rand_mem();
        drive($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d1;
        rst = 1'b1;
        stall = 1'($urandom_range(0, 1));
        flush = 1'($urandom_range(0, 1));
        rand_mem();
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 4'd6;
        step();
        rand_mem();
        step();
        d1 = 16'($urandom);
        SrcReg1 = 4'd0; SrcData1 = d1;
        SrcReg2 = 4'd6; SrcData2 = 16'h5555;
        #1;
        total++; if (WriteReg !== 1'b0) begin bad++; $display("FAIL reset_writereg got=%b want=0", WriteReg); end
        total++; if (instret !== 16'd0) begin bad++; $display("FAIL reset_instret got=%h want=0000", instret); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        total++; if (byp_data1 !== d1) begin bad++; $display("FAIL reset_byp1 got=%h want=%h", byp_data1, d1); end
        total++; if (DstData !== 16'd0 || DstReg !== 4'd0) begin bad++; $display("FAIL reset_dst got=%h/%h want=0/0", DstReg, DstData); end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_wb_select();
        logic [15:0] want [4];
        want[0] = 16'h1234; want[1] = 16'hBEEF; want[2] = 16'h0042; want[3] = 16'h1234;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4'd5, 2'(i), 16'h1234, 16'hBEEF, 16'h0042, 0);
            step();
            total++;
            if (WriteReg !== 1'b1 || DstReg !== 4'd5 || DstData !== want[i]) begin
                bad++;
                $display("FAIL wbsel_%0d got=%b/%h/%h want=1/5/%h", i, WriteReg, DstReg, DstData, want[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (instret !== 16'd4) begin bad++; $display("FAIL wbsel_instret got=%0d want=4", instret); end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1, 1, 4'd3, 2'd0, 16'hA5A5, 16'h0, 16'h0, 0);
        step();
        SrcReg1 = 4'd3; SrcData1 = 16'h0000;
        SrcReg2 = 4'd4; SrcData2 = 16'h1111;
        #1;
        total++; if (byp_data1 !== 16'hA5A5) begin bad++; $display("FAIL byp_hit got=%h want=a5a5", byp_data1); end
        total++; if (byp_data2 !== 16'h1111) begin bad++; $display("FAIL byp_miss got=%h want=1111", byp_data2); end
        drive(1, 1, 4'd0, 2'd0, 16'hFFFF, 16'h0, 16'h0, 0);
        step();
        SrcReg1 = 4'd0; SrcData1 = 16'h2222;
        SrcReg2 = 4'd0; SrcData2 = 16'h3333;
        #1;
        total++; if (WriteReg !== 1'b0) begin bad++; $display("FAIL r0_writereg got=%b want=0", WriteReg); end
        total++; if (byp_data1 !== 16'h2222) begin bad++; $display("FAIL r0_byp got=%h want=2222", byp_data1); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1, 1, 4'd7, 2'd0, 16'h7777, 16'h0, 16'h0, 0);
        step();
        total++; if (WriteReg !== 1'b1) begin bad++; $display("FAIL stall_first got=%b want=1", WriteReg); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_mem();
            step();
            total++;
            if (WriteReg !== 1'b0 || DstReg !== 4'd7) begin
                bad++;
                $display("FAIL stall_hold_%0d got=%b/%h want=0/7", i, WriteReg, DstReg);
            end
        end
        stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (instret !== 16'd1) begin bad++; $display("FAIL stall_instret got=%0d want=1", instret); end
        stall = 1'b1; flush = 1'b1;
        drive(1, 1, 4'd9, 2'd0, 16'h9999, 16'h0, 16'h0, 0);
        step();
        total++; if (WriteReg !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", WriteReg); end
        stall = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (instret !== 16'd1) begin bad++; $display("FAIL flush_instret got=%0d want=1", instret); end
    endtask

    task automatic test_halt();
        do_reset();
        drive(1, 1, 4'd1, 2'd0, 16'h0011, 16'h0, 16'h0, 0);
        step();
        drive(1, 1, 4'd1, 2'd0, 16'h0022, 16'h0, 16'h0, 0);
        step();
        drive(1, 0, 4'd0, 2'd0, 16'h0, 16'h0, 16'h0, 1);
        step();
        total++; if (WriteReg !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL halt_wbcycle got=%b/%b want=0/0", WriteReg, halted); end
        drive(1, 1, 4'd2, 2'd0, 16'hBEEF, 16'h0, 16'h0, 0);
        step();
        SrcReg1 = 4'd2; SrcData1 = 16'h0101;
        #1;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_rise got=%b want=1", halted); end
        total++; if (WriteReg !== 1'b0) begin bad++; $display("FAIL halt_suppress got=%b want=0", WriteReg); end
        total++; if (byp_data1 !== 16'h0101) begin bad++; $display("FAIL halt_byp got=%h want=0101", byp_data1); end
        drive(1, 1, 4'd4, 2'd0, 16'h4444, 16'h0, 16'h0, 0);
        step();
        step();
        total++; if (instret !== 16'd3 || halted !== 1'b1) begin bad++; $display("FAIL halt_frozen got=%0d/%b want=3/1", instret, halted); end
        rst = 1'b1;
        step();
        total++; if (halted !== 1'b0 || WriteReg !== 1'b0 || instret !== 16'd0) begin bad++; $display("FAIL halt_rst got=%b/%b/%0d want=0/0/0", halted, WriteReg, instret); end
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            rand_mem();
            mem_halt = ($urandom_range(0, 199) == 0);
            SrcReg1  = ($urandom_range(0, 1) == 1) ? m_wb.rd : 4'($urandom_range(0, 15));
            SrcReg2  = ($urandom_range(0, 1) == 1) ? m_wb.rd : 4'($urandom_range(0, 15));
            SrcData1 = 16'($urandom);
            SrcData2 = 16'($urandom);
            #1;
            total++;
            if (WriteReg !== m_write() || DstReg !== m_wb.rd || DstData !== m_value()) begin
                bad++;
                $display("FAIL rand_wb n=%0d got=%b/%h/%h want=%b/%h/%h", n, WriteReg, DstReg, DstData, m_write(), m_wb.rd, m_value());
            end
            total++;
            if (byp_data1 !== m_byp(SrcReg1, SrcData1) || byp_data2 !== m_byp(SrcReg2, SrcData2)) begin
                bad++;
                $display("FAIL rand_byp n=%0d got=%h/%h want=%h/%h", n, byp_data1, byp_data2, m_byp(SrcReg1, SrcData1), m_byp(SrcReg2, SrcData2));
            end
            total++;
            if (halted !== m_halted || instret !== m_cnt) begin
                bad++;
                $display("FAIL rand_state n=%0d got=%b/%h want=%b/%h", n, halted, instret, m_halted, m_cnt);
            end
            step();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 0, 4'd0, 2'd0, 16'h0, 16'h0, 16'h0, 0);
        repeat (65536) step();
        total++; if (instret !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffff", instret); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        total++; if (instret !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", instret); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        SrcReg1 = 4'd0; SrcReg2 = 4'd0; SrcData1 = 16'd0; SrcData2 = 16'd0;
        test_reset();
        test_wb_select();
        test_bypass();
        test_stall_flush();
        test_halt();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
